// File: rtl/fp_dot_acc_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_dot_acc_unit: sequential FP32 dot-product accumulator, truncating (RTZ) with denormal flush; FP_DOT_CHAIN_EN adds in_chain result chaining. Rev 1.0
// ---------------------------------------------------------------------------
module fp_dot_acc_unit #(
  parameter int LANES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
`ifdef FP_DOT_CHAIN_EN
  input  logic                  in_chain,
`endif
  output logic                  in_ready,
  input  logic [31:0]           previous,
  input  logic [32*LANES-1:0]   array1,
  input  logic [32*LANES-1:0]   array2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out
);

  localparam int              KW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(LANES - 1);
  localparam logic [31:0]     QNAN   = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

  state_t        r_state;
  logic [KW-1:0] r_k;
  logic [31:0]   r_acc;
  logic [31:0]   r_p;
  logic [31:0]   r_a [LANES];
  logic [31:0]   r_b [LANES];
  logic [31:0]   w_prod;
  logic [31:0]   w_sum;
  logic [31:0]   w_seed;
`ifdef FP_DOT_CHAIN_EN
  logic [31:0]   r_last;
`endif

  function automatic logic [31:0] ftz(input logic [31:0] x);
    return (x[30:23] == 8'd0 && x[22:0] != 23'd0) ? 32'd0 : x;
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (&x[30:23]) && !(|x[22:0]);
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] a, b, r;
    logic [47:0] prod;
    logic [9:0]  e;
    logic [22:0] frac;
    logic        s;
    a    = ftz(a_in);
    b    = ftz(b_in);
    s    = a[31] ^ b[31];
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e    = 10'({2'b00, a[30:23]}) + 10'({2'b00, b[30:23]}) - 10'd127;
    if (prod[47]) begin
      e    = e + 10'd1;
      frac = prod[46:24];
    end else begin
      frac = prod[45:23];
    end
    if (is_nan(a) || is_nan(b))
      r = QNAN;
    else if ((is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a)))
      r = QNAN;
    else if (is_inf(a) || is_inf(b))
      r = {s, 8'hFF, 23'd0};
    else if (is_zero(a) || is_zero(b))
      r = {s, 31'd0};
    else if ($signed(e) >= 10'sd255)
      r = {s, 8'hFF, 23'd0};
    else if ($signed(e) <= 10'sd0)
      r = 32'd0;
    else
      r = {s, e[7:0], frac};
    return r;
  endfunction

  // Three guard bits plus a sticky LSB keep truncation exact even under subtraction.
  function automatic logic [31:0] fp_add(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] a, b, big, sml, r;
    logic [7:0]  d;
    logic [26:0] mb, ms0, ms, shv, norm;
    logic [27:0] sum;
    logic [9:0]  e;
    logic [22:0] frac;
    logic        lost;
    int          pos, sh;
    a    = ftz(a_in);
    b    = ftz(b_in);
    big  = (b[30:0] > a[30:0]) ? b : a;
    sml  = (b[30:0] > a[30:0]) ? a : b;
    d    = big[30:23] - sml[30:23];
    mb   = {1'b1, big[22:0], 3'b000};
    ms0  = {1'b1, sml[22:0], 3'b000};
    shv  = ms0 >> d;
    lost = |(ms0 & ~({27{1'b1}} << d));
    ms   = (d >= 8'd27) ? 27'd1 : {shv[26:1], shv[0] | lost};
    sum  = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
    pos  = 0;
    for (int i = 0; i < 27; i++)
      if (sum[i]) pos = i;
    sh   = 26 - pos;
    norm = sum[26:0] << sh;
    if (sum[27]) begin
      e    = {2'b00, big[30:23]} + 10'd1;
      frac = sum[26:4];
    end else begin
      e    = {2'b00, big[30:23]} - 10'(sh);
      frac = norm[25:3];
    end
    if (is_nan(a) || is_nan(b))
      r = QNAN;
    else if (is_inf(a) && is_inf(b) && (a[31] != b[31]))
      r = QNAN;
    else if (is_inf(a))
      r = a;
    else if (is_inf(b))
      r = b;
    else if (is_zero(a) && is_zero(b))
      r = {a[31] & b[31], 31'd0};
    else if (is_zero(a))
      r = b;
    else if (is_zero(b))
      r = a;
    else if (sum == 28'd0)
      r = 32'd0;
    else if ($signed(e) >= 10'sd255)
      r = {big[31], 8'hFF, 23'd0};
    else if ($signed(e) <= 10'sd0)
      r = 32'd0;
    else
      r = {big[31], e[7:0], frac};
    return r;
  endfunction

  assign w_prod = fp_mul(r_a[r_k], r_b[r_k]);
  assign w_sum  = fp_add(r_acc, r_p);

`ifdef FP_DOT_CHAIN_EN
  assign w_seed = in_chain ? r_last : previous;
`else
  assign w_seed = previous;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_acc     <= '0;
      r_p       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef FP_DOT_CHAIN_EN
      r_last    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc    <= w_seed;
            r_k      <= '0;
            in_ready <= 1'b0;
            r_state  <= MUL;
            for (int i = 0; i < LANES; i++) begin
              r_a[i] <= array1[i*32 +: 32];
              r_b[i] <= array2[i*32 +: 32];
            end
          end
        end
        MUL: begin
          r_p     <= w_prod;
          r_state <= ADD;
        end
        ADD: begin
          r_acc <= w_sum;
          if (r_k == K_LAST) begin
            out       <= w_sum;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_k     <= r_k + 1'b1;
            r_state <= MUL;
          end
        end
        DONE: begin
          if (out_ready) begin
`ifdef FP_DOT_CHAIN_EN
            r_last    <= r_acc;
`endif
            out       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_dot_acc_unit.sv
`default_nettype none
// Scoreboard bench for fp_dot_acc_unit: random FP32 operand sets against an exact-integer reference model.
module tb_fp_dot_acc_unit;
  localparam int LANES = 2;
  localparam int LAT   = 2 * LANES;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         previous;
  logic [32*LANES-1:0] array1;
  logic [32*LANES-1:0] array2;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out;
`ifdef FP_DOT_CHAIN_EN
  logic                in_chain;
`endif

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] va [LANES];
  logic [31:0] vb [LANES];
  logic [31:0] model_last;
  bit          prev_rst   = 1'b1;
  bit          prev_hs    = 1'b0;
  bit          prev_valid = 1'b0;

  fp_dot_acc_unit #(.LANES(LANES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
`ifdef FP_DOT_CHAIN_EN
    .in_chain (in_chain),
`endif
    .in_ready (in_ready),
    .previous (previous),
    .array1   (array1),
    .array2   (array2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------- reference model: exact values, then truncate ----------------
  function automatic logic [31:0] m_ftz(input logic [31:0] x);
    return (x[30:23] == 8'd0 && x[22:0] != 23'd0) ? 32'd0 : x;
  endfunction
  function automatic bit m_nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 23'd0;
  endfunction
  function automatic bit m_inf(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] == 23'd0;
  endfunction
  function automatic bit m_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

  // Value is mag * 2^scale; keep the top 24 bits of mag, dropping the rest.
  function automatic logic [31:0] m_pack(input logic s, input logic [299:0] mag, input int scale);
    int p = -1;
    int be;
    logic [299:0] t;
    if (mag == '0) return 32'd0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    be = p + scale + 127;
    if (be >= 255) return {s, 8'hFF, 23'd0};
    if (be <= 0) return 32'd0;
    t = (p >= 23) ? (mag >> (p - 23)) : (mag << (23 - p));
    return {s, be[7:0], t[22:0]};
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] ai, input logic [31:0] bi);
    logic [31:0] a, b;
    logic s;
    a = m_ftz(ai); b = m_ftz(bi); s = a[31] ^ b[31];
    if (m_nan(a) || m_nan(b)) return 32'h7FC00000;
    if ((m_inf(a) && m_zero(b)) || (m_inf(b) && m_zero(a))) return 32'h7FC00000;
    if (m_inf(a) || m_inf(b)) return {s, 8'hFF, 23'd0};
    if (m_zero(a) || m_zero(b)) return {s, 31'd0};
    return m_pack(s, 300'({1'b1, a[22:0]}) * 300'({1'b1, b[22:0]}),
                  int'(a[30:23]) + int'(b[30:23]) - 300);
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] ai, input logic [31:0] bi);
    logic [31:0] a, b;
    logic [299:0] ma, mb;
    int ea, eb, emin;
    a = m_ftz(ai); b = m_ftz(bi);
    if (m_nan(a) || m_nan(b)) return 32'h7FC00000;
    if (m_inf(a) && m_inf(b) && a[31] != b[31]) return 32'h7FC00000;
    if (m_inf(a)) return a;
    if (m_inf(b)) return b;
    if (m_zero(a) && m_zero(b)) return {a[31] & b[31], 31'd0};
    if (m_zero(a)) return b;
    if (m_zero(b)) return a;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    emin = (ea < eb) ? ea : eb;
    ma = 300'({1'b1, a[22:0]}) << (ea - emin);
    mb = 300'({1'b1, b[22:0]}) << (eb - emin);
    if (a[31] == b[31]) return m_pack(a[31], ma + mb, emin - 150);
    if (ma > mb) return m_pack(a[31], ma - mb, emin - 150);
    if (mb > ma) return m_pack(b[31], mb - ma, emin - 150);
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_dot(input logic [31:0] seed);
    logic [31:0] acc = seed;
    for (int k = 0; k < LANES; k++) acc = m_add(acc, m_mul(va[k], vb[k]));
    return acc;
  endfunction

  function automatic logic [31:0] rand_fp();
    int r = $urandom_range(0, 99);
    logic s = 1'($urandom);
    logic [22:0] f = 23'($urandom);
    if (r < 6)  return {s, 31'd0};
    if (r < 9)  return {s, 8'hFF, 23'd0};
    if (r < 12) return {s, 8'hFF, f | 23'd1};
    if (r < 15) return {s, 8'd0, f | 23'd1};
    if (r < 25) return {s, 8'($urandom_range(200, 254)), f};
    return {s, 8'($urandom_range(110, 144)), f};
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [31:0] prev, input bit chain);
    exp_t it;
    bit   ok = 1'b0;
    logic [31:0] seed;
    previous = prev;
    for (int k = 0; k < LANES; k++) begin
      array1[k*32 +: 32] = va[k];
      array2[k*32 +: 32] = vb[k];
    end
`ifdef FP_DOT_CHAIN_EN
    in_chain = chain;
    seed = chain ? model_last : prev;
`else
    seed = prev;
`endif
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout: in_ready=%b expected 1", in_ready);
    end
    @(posedge clk); #1;
    it.val = m_dot(seed);
    it.cyc = cyc;
    q.push_back(it);
    model_last = it.val;
    in_valid = 1'b0;
    previous = $urandom;
    for (int k = 0; k < LANES; k++) begin
      array1[k*32 +: 32] = $urandom;
      array2[k*32 +: 32] = $urandom;
    end
`ifdef FP_DOT_CHAIN_EN
    in_chain = 1'($urandom);
`endif
  endtask

  task automatic take_result(input int hold);
    bit ok = 1'b0;
    for (int t = 0; t < 4 * LANES + 20; t++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL result_timeout: out_valid=%b expected 1", out_valid);
    end
    repeat (hold) @(posedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic clear_ops();
    for (int k = 0; k < LANES; k++) begin va[k] = 32'd0; vb[k] = 32'd0; end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (prev_rst && !rst) begin
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out", out, 32'd0);
      end else if (prev_hs && !rst) begin
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
      end
      if (!rst) begin
        if (!out_valid) begin
          check("out_zero_when_invalid", out, 32'd0);
        end else begin
          check("in_ready_in_done", 32'(in_ready), 32'd0);
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: out=%h with no pending operation", out);
          end else begin
            check("result", out, q[0].val);
            if (!prev_valid) check("latency", 32'(cyc - q[0].cyc), 32'(LAT));
            if (out_ready) void'(q.pop_front());
          end
        end
      end
      prev_rst   = rst;
      prev_hs    = !rst && out_valid && out_ready;
      prev_valid = !rst && out_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; previous = 32'd0;
    array1 = '0; array2 = '0; model_last = 32'd0;
`ifdef FP_DOT_CHAIN_EN
    in_chain = 1'b0;
`endif
    clear_ops();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 10 + 1.5*-3 + -2.75*2 cancels to +0
    va[0] = 32'h3FC00000; va[1] = 32'hC0300000;
    vb[0] = 32'hC0400000; vb[1] = 32'h40000000;
    send(32'h41200000, 1'b0); take_result(0);
    // same operands from 1.0 give -9, held for several cycles
    send(32'h3F800000, 1'b0); take_result(4);
`ifdef FP_DOT_CHAIN_EN
    clear_ops(); va[0] = 32'h3F800000; vb[0] = 32'h40000000;
    send(32'h42000000, 1'b1); take_result(1);
`endif
    clear_ops(); va[0] = 32'h7F000000; vb[0] = 32'h7F000000;
    send(32'd0, 1'b0); take_result(0);
    va[0] = 32'h7FC00000;
    send(32'd0, 1'b0); take_result(2);
    for (int k = 0; k < LANES; k++) begin va[k] = 32'h3F800000; vb[k] = 32'h3F800000; end
    send(32'd0, 1'b0); take_result(0);

    // reset while lane 0 is in its add step
    for (int k = 0; k < LANES; k++) begin va[k] = rand_fp(); vb[k] = rand_fp(); end
    send(rand_fp(), 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    void'(q.pop_back());
    model_last = 32'd0;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < LANES; k++) begin va[k] = rand_fp(); vb[k] = rand_fp(); end
    send(rand_fp(), 1'b0); take_result(1);

    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < LANES; k++) begin va[k] = rand_fp(); vb[k] = rand_fp(); end
      send(rand_fp(), 1'($urandom_range(0, 3) == 0));
      take_result($urandom_range(0, 3));
    end

    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    check("queue_drained", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_dot_acc_unit.md
FP_DOT_ACC_UNIT -- requirements
Module: fp_dot_acc_unit

Interface
REQ-001 Parameter LANES, default 2, sets the number of multiply pairs per operation; legal range 1..16.
REQ-002 Clock and reset: one clock, clk; reset rst is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  unit can accept an operand set.
REQ-007 previous  input  32  IEEE-754 single seed addend.
REQ-008 array1  input  32*LANES  lane k operand A at bits [32k+31:32k].
REQ-009 array2  input  32*LANES  lane k operand B, same packing.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 out  output  32  result = previous + sum over k of array1[k]*array2[k], accumulated in lane order 0..LANES-1.

Function
REQ-013 FSM states: IDLE, MUL, ADD, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 IDLE: on in_valid&&in_ready, register previous into acc, register all operands, clear lane index k to 0, go to MUL.
REQ-015 MUL: register product p = A[k]*B[k]; go to ADD.
REQ-016 ADD: acc <= acc + p; if k==LANES-1 go to DONE, else k<=k+1 and go to MUL.
REQ-017 Latency: out_valid rises after the 2*LANES-th rising edge following the accepting edge (4 edges for LANES=2).
REQ-018 DONE: out holds acc stable; on out_ready go to IDLE; out_valid deasserts on the next edge.
REQ-019 Inputs changing outside the accepting edge SHALL NOT affect the result.
REQ-020 Arithmetic: round toward zero (truncate) in both multiply and add; denormal inputs and results are flushed to +0.
REQ-021 Exponent overflow SHALL produce correctly signed infinity; exponent underflow SHALL produce +0.
REQ-022 Exact cancellation in add SHALL produce +0; 0*x SHALL produce a zero with sign A^B.
REQ-023 Any NaN operand, Inf*0, or Inf + (-Inf) SHALL produce quiet NaN 0x7FC00000, which propagates through the remaining lanes.
REQ-024 out SHALL be 0 whenever out_valid is 0.

Reset
REQ-025 rst SHALL force state IDLE, k=0, acc=0, product register=0, out=0, out_valid=0, and in_ready=1 on the following cycle.
REQ-026 rst asserted in MUL, ADD or DONE SHALL abandon the operation with no result emitted; rst has priority over all handshakes.

Configuration
REQ-027 Macro FP_DOT_CHAIN_EN, when defined, SHALL add input in_chain (1 bit); on accept with in_chain=1, acc seeds from the last delivered result instead of previous.
REQ-028 With FP_DOT_CHAIN_EN, the last-result register SHALL load on each DONE->IDLE transfer, and rst SHALL clear it to 0.
REQ-029 Without FP_DOT_CHAIN_EN, port in_chain and the last-result register SHALL NOT exist, and previous is always the seed.

Verification
REQ-030 LANES=2, previous=0x41200000 (10), A=(0x3FC00000 1.5, 0xC0300000 -2.75), B=(0xC0400000 -3, 0x40000000 2) -> out=0x00000000 (+0), out_valid rises 4 edges after accept.
REQ-031 Same operands with previous=0x3F800000 (1), out_ready held 0 for 5 cycles -> out=0xC1100000 (-9) stays stable and valid, in_ready stays 0, IDLE is re-entered one edge after out_ready=1.
REQ-032 A[0]=0x7F000000, B[0]=0x7F000000 -> out=0x7F800000 (+Inf); A[0]=0x7FC00000 -> out=0x7FC00000.
REQ-033 rst pulsed during the ADD state of lane 0 -> no out_valid, in_ready=1 next cycle, and a new operand set gives the correct result.
REQ-034 FP_DOT_CHAIN_EN: first op gives -9 (REQ-031 set); second op with in_chain=1, A=(1.0,0), B=(2.0,0) -> out=0xC0E00000 (-7).
REQ-035 LANES=1 and LANES=16 builds with all-ones products and previous=0 -> out equals LANES as a float (0x3F800000, 0x41800000) at latency 2*LANES.
